// File: rtl/pci_edu_pkg.sv
// pci_edu_pkg: shared register map, STATUS bit positions and factorial FSM encoding
// for the PCI Edu BAR0 register block.  Rev 1.0
`default_nettype none

package pci_edu_pkg;

   localparam logic [7:0] OFF_ID        = 8'h00;
   localparam logic [7:0] OFF_LIVENESS  = 8'h04;
   localparam logic [7:0] OFF_FACT      = 8'h08;
   localparam logic [7:0] OFF_STATUS    = 8'h20;
   localparam logic [7:0] OFF_IRQ_STAT  = 8'h24;
   localparam logic [7:0] OFF_IRQ_RAISE = 8'h60;
   localparam logic [7:0] OFF_IRQ_ACK   = 8'h64;

   localparam int STATUS_BUSY_BIT   = 0;
   localparam int STATUS_IRQ_EN_BIT = 7;

   typedef enum logic [1:0] {
      FACT_IDLE = 2'd0,
      FACT_MUL  = 2'd1,
      FACT_DONE = 2'd2
   } fact_state_t;

   // Expand byte enables into a 32-bit bit mask.
   function automatic logic [31:0] be_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pci_edu_fact.sv
// pci_edu_fact: iterative N! engine (mod 2^32), one multiply per cycle.  Rev 1.0
`default_nettype none

module pci_edu_fact
   import pci_edu_pkg::*;
#(
   parameter int FACT_LIMIT = 34
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] n,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   fact_state_t state, state_nx;
   logic [31:0] acc, acc_nx;
   logic [31:0] cnt, cnt_nx;
   logic [31:0] result_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FACT_IDLE;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         cnt    <= cnt_nx;
         result <= result_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      cnt_nx    = cnt;
      result_nx = result;
      case (state)
         FACT_IDLE: begin
            if (start) begin
               acc_nx   = 32'd1;
               cnt_nx   = n;
               state_nx = FACT_MUL;
            end
         end
         FACT_MUL: begin
            // Any N >= limit has at least 32 factors of two, so the result is 0.
            if (cnt >= 32'(FACT_LIMIT)) begin
               acc_nx   = '0;
               state_nx = FACT_DONE;
            end else if (cnt <= 32'd1) begin
               state_nx = FACT_DONE;
            end else begin
               acc_nx = acc * cnt;
               cnt_nx = cnt - 32'd1;
            end
         end
         FACT_DONE: begin
            result_nx = acc;
            state_nx  = FACT_IDLE;
         end
         default: state_nx = FACT_IDLE;
      endcase
   end

   assign busy = (state != FACT_IDLE);
   assign done = (state == FACT_DONE);

endmodule

`default_nettype wire

// File: rtl/pci_edu_regs.sv
// pci_edu_regs: BAR0 register block of the PCI Edu device (ID, liveness, factorial,
// interrupt status/raise/ack) with 1-cycle read/write ack and level interrupt.  Rev 1.0
`default_nettype none

module pci_edu_regs
   import pci_edu_pkg::*;
#(
   parameter logic [31:0] ID_VAL     = 32'h010000ed,
   parameter int          FACT_LIMIT = 34
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_enable,
   input  logic        mem_iswrite,
   input  logic [7:0]  mem_offset,
   input  logic [3:0]  mem_be,
   input  logic [31:0] mem_write_val,
   output logic [31:0] mem_read_val,
   output logic        mem_ack,
   output logic        intx_req
);

   logic [31:0] liveness;
   logic        irq_en;
   logic [31:0] irq_status, irq_status_nx;

   logic [7:0]  addr;
   logic [31:0] wmask, wdata;
   logic        wr, rd;
   logic        wr_live, wr_fact, wr_status, wr_raise, wr_ack;
   logic        fact_start, fact_busy, fact_done;
   logic [31:0] fact_result;
   logic [31:0] rdata;

   assign addr  = {mem_offset[7:2], 2'b00};
   assign wmask = be_mask(mem_be);
   assign wdata = mem_write_val & wmask;
   assign wr    = mem_enable & mem_iswrite;
   assign rd    = mem_enable & ~mem_iswrite;

   assign wr_live   = wr && (addr == OFF_LIVENESS);
   assign wr_fact   = wr && (addr == OFF_FACT);
   assign wr_status = wr && (addr == OFF_STATUS) && mem_be[0];
   assign wr_raise  = wr && (addr == OFF_IRQ_RAISE);
   assign wr_ack    = wr && (addr == OFF_IRQ_ACK);

   // A write with no bytes enabled carries no operand and must not start a run.
   assign fact_start = wr_fact && (|mem_be) && !fact_busy;

   pci_edu_fact #(
      .FACT_LIMIT (FACT_LIMIT)
   ) u_fact (
      .clk    (clk),
      .rst    (rst),
      .start  (fact_start),
      .n      (wdata),
      .busy   (fact_busy),
      .done   (fact_done),
      .result (fact_result)
   );

   // Completion is OR-ed in last so it survives an ACK of bit 0 in the same cycle.
   always_comb begin
      irq_status_nx = irq_status;
      if (wr_raise)
         irq_status_nx = irq_status_nx | wdata;
      if (wr_ack)
         irq_status_nx = irq_status_nx & ~wdata;
      if (fact_done && irq_en)
         irq_status_nx[0] = 1'b1;
   end

   always_comb begin
      rdata = '0;
      case (addr)
         OFF_ID:       rdata = ID_VAL;
         OFF_LIVENESS: rdata = ~liveness;
         OFF_FACT:     rdata = fact_result;
         OFF_STATUS: begin
            rdata[STATUS_BUSY_BIT]   = fact_busy;
            rdata[STATUS_IRQ_EN_BIT] = irq_en;
         end
         OFF_IRQ_STAT: rdata = irq_status;
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         liveness     <= '0;
         irq_en       <= 1'b0;
         irq_status   <= '0;
         intx_req     <= 1'b0;
         mem_ack      <= 1'b0;
         mem_read_val <= '0;
      end else begin
         if (wr_live)
            liveness <= (liveness & ~wmask) | wdata;
         if (wr_status)
            irq_en <= mem_write_val[STATUS_IRQ_EN_BIT];
         irq_status   <= irq_status_nx;
         intx_req     <= |irq_status;
         mem_ack      <= mem_enable;
         mem_read_val <= rd ? rdata : '0;
      end
   end

endmodule

`default_nettype wire
